// File: rtl/sync_self_test_gen_pkg.sv
// Shared types for the multi-channel self-test pulse generator.
// Used by sync_self_test_gen (optional SELF_TEST_LOOPBACK_EN feature) and self_test_channel.
package sync_self_test_gen_pkg;

    localparam int SELF_TEST_MAX_CH = 16;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RUN,
        DONE
    } self_test_state_t;

endpackage

// File: rtl/sync_self_test_gen_channel.sv
// One self-test output channel: registered pulse while phase is inside
// the window [offset, offset+width).
module self_test_channel
    import sync_self_test_gen_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int OFF_W = 19
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [CNT_W-1:0] phase_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic             enable_i,
    output logic             pulse_o
);

    logic [OFF_W-1:0] phase_ext;
    logic [OFF_W-1:0] end_ext;
    logic             window;
    logic             pulse_d;
    logic             pulse_q;

    assign phase_ext = OFF_W'(phase_i);
    assign end_ext   = offset_i + OFF_W'(width_i);
    assign window    = (phase_ext >= offset_i) && (phase_ext < end_ext);
    assign pulse_d   = enable_i & window;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/sync_self_test_gen.sv
// Multi-channel skewed periodic self-test pulse generator with config check.
// Define SELF_TEST_LOOPBACK_EN to add the loopback compare (loopback_in_i, mismatch_cnt_o).
module sync_self_test_gen
    import sync_self_test_gen_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int REP_W    = 16,
    parameter int LB_DELAY = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] skew_i,
    input  logic [REP_W-1:0] repeat_count_i,
    input  logic [N_CH-1:0]  ch_mask_i,
    output logic [N_CH-1:0]  pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_error_o,
    output logic [REP_W-1:0] cycle_idx_o
`ifdef SELF_TEST_LOOPBACK_EN
    ,
    input  logic [N_CH-1:0]  loopback_in_i,
    output logic [CNT_W-1:0] mismatch_cnt_o
`endif
);

    localparam int SUM_W = CNT_W + $clog2(N_CH) + 1;

    if (N_CH < 1 || N_CH > SELF_TEST_MAX_CH || LB_DELAY < 1) begin : g_param_check
        $error("sync_self_test_gen: unsupported N_CH or LB_DELAY");
    end

    self_test_state_t state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [REP_W-1:0] cycle_q, cycle_d;
    logic             cfg_err_q, cfg_err_d;

    logic [CNT_W-1:0] period_q, width_q, skew_q;
    logic [REP_W-1:0] rep_q;
    logic [N_CH-1:0]  mask_q;

    logic             accept;
    logic             cfg_ok;
    logic             last_phase;
    logic             run_en;
    logic [SUM_W-1:0] span;

    assign span = SUM_W'(N_CH - 1) * SUM_W'(skew_q) + SUM_W'(width_q);
    assign cfg_ok = (period_q >= CNT_W'(2)) && (width_q != '0) && (span <= SUM_W'(period_q));
    assign last_phase = (phase_q == period_q - CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cycle_d   = cycle_q;
        cfg_err_d = cfg_err_q;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    accept    = 1'b1;
                    cfg_err_d = 1'b0;
                    cycle_d   = '0;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (cfg_ok) begin
                    state_d = RUN;
                    phase_d = '0;
                end else begin
                    cfg_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            RUN: begin
                // stop beats completion; cycle count is left as it stood
                if (stop_i) begin
                    state_d = IDLE;
                end else if (last_phase) begin
                    phase_d = '0;
                    cycle_d = cycle_q + REP_W'(1);
                    if (rep_q != '0 && cycle_d == rep_q) begin
                        state_d = DONE;
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            cycle_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cycle_q   <= cycle_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (accept) begin
            period_q <= period_i;
            width_q  <= width_i;
            skew_q   <= skew_i;
            rep_q    <= repeat_count_i;
            mask_q   <= ch_mask_i;
        end
    end

    // Pulses only register while staying in RUN, so stop/DONE force them low at once
    assign run_en = (state_q == RUN) && (state_d == RUN);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SUM_W-1:0] offset;
        assign offset = SUM_W'(i) * SUM_W'(skew_q);

        self_test_channel #(
            .CNT_W (CNT_W),
            .OFF_W (SUM_W)
        ) u_ch (
            .clock_i  (clock_i),
            .reset_i  (reset_i),
            .phase_i  (phase_q),
            .offset_i (offset),
            .width_i  (width_q),
            .enable_i (run_en & mask_q[i]),
            .pulse_o  (pulse_o[i])
        );
    end

    assign busy_o      = (state_q == CHECK) || (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign cfg_error_o = cfg_err_q;
    assign cycle_idx_o = cycle_q;

`ifdef SELF_TEST_LOOPBACK_EN
    logic [N_CH-1:0]     pulse_dly_q [LB_DELAY];
    logic [LB_DELAY-1:0] busy_dly_q;
    logic [CNT_W-1:0]    mismatch_q, mismatch_d;

    always_ff @(posedge clock_i) begin
        pulse_dly_q[0] <= pulse_o;
        for (int k = 1; k < LB_DELAY; k++) begin
            pulse_dly_q[k] <= pulse_dly_q[k-1];
        end
    end

    always_comb begin
        mismatch_d = mismatch_q;
        if (accept) begin
            mismatch_d = '0;
        end else if (busy_dly_q[LB_DELAY-1] && (pulse_dly_q[LB_DELAY-1] != loopback_in_i)
                     && (mismatch_q != '1)) begin
            mismatch_d = mismatch_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy_dly_q <= '0;
            mismatch_q <= '0;
        end else begin
            busy_dly_q[0] <= busy_o;
            for (int k = 1; k < LB_DELAY; k++) begin
                busy_dly_q[k] <= busy_dly_q[k-1];
            end
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch_cnt_o = mismatch_q;
`endif

endmodule

// File: tb/tb_sync_self_test_gen.sv
// Bench for sync_self_test_gen: table of configurations checked cycle by cycle
// against an analytic pulse model, plus stop/reset/start-collision sequences.
module tb_sync_self_test_gen;

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [15:0] period, width, skew, rep;
    logic [3:0]  mask;
    logic [3:0]  pulse;
    logic        busy, done, cfg_error;
    logic [15:0] cycle_idx;
`ifdef SELF_TEST_LOOPBACK_EN
    logic [3:0]  lb_in, lb_d1, lb_d2;
    logic [15:0] mismatch;
    logic        kill2 = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sync_self_test_gen #(.N_CH(4), .CNT_W(16), .REP_W(16), .LB_DELAY(2)) dut (
        .clock_i        (clk),
        .reset_i        (reset),
        .start_i        (start),
        .stop_i         (stop),
        .period_i       (period),
        .width_i        (width),
        .skew_i         (skew),
        .repeat_count_i (rep),
        .ch_mask_i      (mask),
        .pulse_o        (pulse),
        .busy_o         (busy),
        .done_o         (done),
        .cfg_error_o    (cfg_error),
        .cycle_idx_o    (cycle_idx)
`ifdef SELF_TEST_LOOPBACK_EN
        ,
        .loopback_in_i  (lb_in),
        .mismatch_cnt_o (mismatch)
`endif
    );

`ifdef SELF_TEST_LOOPBACK_EN
    always @(posedge clk) begin
        lb_d1 <= pulse;
        lb_d2 <= lb_d1;
    end
    assign lb_in = kill2 ? (lb_d2 & 4'b1011) : lb_d2;
`endif

    typedef struct {
        logic [15:0] period, width, skew, rep;
        logic [3:0]  mask;
        bit          bad;
    } vec_t;

    typedef struct {
        logic [3:0]  pulse;
        logic        busy, done, err;
        logic [15:0] cyc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected outputs just after the k-th edge counted from the edge sampling start
    function automatic exp_t model(vec_t v, int k);
        exp_t e;
        int p, d, ph, c;
        e.pulse = '0; e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0; e.cyc = '0;
        if (v.bad) begin
            e.busy = (k == 0);
            e.err  = (k >= 1);
            return e;
        end
        p = int'(v.period);
        d = (v.rep == 0) ? (1 << 30) : 1 + int'(v.rep) * p;
        e.busy = (k < d);
        e.done = (k == d);
        c = (k >= 1) ? (k - 1) / p : 0;
        if (v.rep != 0 && c > int'(v.rep)) c = int'(v.rep);
        e.cyc = 16'(c);
        if (k >= 2 && k < d) begin
            ph = (k - 2) % p;
            for (int i = 0; i < 4; i++)
                if (v.mask[i] && ph >= i * int'(v.skew) && ph < i * int'(v.skew) + int'(v.width))
                    e.pulse[i] = 1'b1;
        end
        return e;
    endfunction

    task automatic compare(input exp_t e, input string tag);
        chk({tag, " pulse"}, pulse, e.pulse);
        chk({tag, " busy"}, busy, e.busy);
        chk({tag, " done"}, done, e.done);
        chk({tag, " cfg_error"}, cfg_error, e.err);
        chk({tag, " cycle_idx"}, cycle_idx, e.cyc);
    endtask

    task automatic run_vec(input vec_t v, input int nedges, input bit hold_start, input string name);
        exp_t e;
        period = v.period; width = v.width; skew = v.skew; rep = v.rep; mask = v.mask;
        start = 1'b1; stop = 1'b0;
        for (int k = 0; k < nedges; k++) begin
            sb_q.push_back(model(v, k));
            tick();
            if (k == 0) begin
                if (!hold_start) start = 1'b0;
                period = 16'd3; width = 16'd9; skew = 16'd7; rep = 16'd1; mask = 4'b1010;
            end
            e = sb_q.pop_front();
            compare(e, $sformatf("%s k%0d", name, k));
        end
        start = 1'b0;
    endtask

    function automatic int run_len(vec_t v);
        return v.bad ? 3 : 3 + int'(v.rep) * int'(v.period);
    endfunction

    initial begin
        vec_t v;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{16'd20, 16'd3, 16'd4, 16'd2, 4'b1111, 1'b0};
        vecs[1] = '{16'd10, 16'd4, 16'd3, 16'd2, 4'b1111, 1'b1};
        vecs[2] = '{16'd8,  16'd1, 16'd1, 16'd3, 4'b0101, 1'b0};
        vecs[3] = '{16'd5,  16'd2, 16'd1, 16'd1, 4'b1111, 1'b0};
        vecs[4] = '{16'd1,  16'd1, 16'd0, 16'd1, 4'b0001, 1'b1};
        vecs[5] = '{16'd4,  16'd0, 16'd0, 16'd1, 4'b1111, 1'b1};
        vecs[6] = '{16'd6,  16'd2, 16'd0, 16'd2, 4'b0000, 1'b0};
        vecs[7] = '{16'd2,  16'd1, 16'd0, 16'd3, 4'b0011, 1'b0};

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        period = '0; width = '0; skew = '0; rep = '0; mask = '0;
        repeat (3) tick();
        compare('{4'b0, 1'b0, 1'b0, 1'b0, 16'd0}, "reset");
`ifdef SELF_TEST_LOOPBACK_EN
        chk("reset mismatch", mismatch, 0);
`endif
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], run_len(vecs[i]), 1'b0, $sformatf("v%0d", i));
            tick();
        end

        // start and stop together in IDLE: no run
        start = 1'b1; stop = 1'b1;
        tick();
        chk("startstop busy0", busy, 0);
        tick();
        chk("startstop busy1", busy, 0);
        start = 1'b0; stop = 1'b0;

        // stop while in CHECK
        v = vecs[0];
        run_vec(v, 1, 1'b0, "chkstop");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        compare('{4'b0, 1'b0, 1'b0, 1'b0, 16'd0}, "chkstop after");
        repeat (3) tick();
        chk("chkstop pulse later", pulse, 0);

        // endless run with start held high, then stop
        v = '{16'd8, 16'd1, 16'd1, 16'd0, 4'b1111, 1'b0};
        run_vec(v, 30, 1'b1, "endless");
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        compare('{4'b0, 1'b0, 1'b0, 1'b0, model(v, 29).cyc}, "stop");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stop idle done k%0d", k), done, 0);
            chk($sformatf("stop idle busy k%0d", k), busy, 0);
        end

        // reset in RUN while pulse[1] high and cycle_idx nonzero
        v = '{16'd5, 16'd2, 16'd1, 16'd0, 4'b1111, 1'b0};
        run_vec(v, 9, 1'b0, "prereset");
        chk("prereset pulse1", pulse[1], 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compare('{4'b0, 1'b0, 1'b0, 1'b0, 16'd0}, "midreset");
        tick();
        run_vec(vecs[0], run_len(vecs[0]), 1'b0, "postreset");

`ifdef SELF_TEST_LOOPBACK_EN
        chk("loopback clean mismatch", mismatch, 0);
        tick();
        kill2 = 1'b1;
        run_vec(vecs[0], run_len(vecs[0]), 1'b0, "lbkill");
        repeat (3) tick();
        chk("loopback bit2 mismatch", mismatch, 6);
        kill2 = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
